// File: rtl/spi_ram_loader_if.sv
// RAM-side bus of the SPI loader: single-cycle enable strobe, write enable,
// address, write data, and combinational read data from the RAM.
interface spi_ram_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Loader side: drives the strobes and address, consumes read data.
  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  // RAM side: accepts the strobes and returns read data.
  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/spi_ram_loader.sv
// SPI mode-0 slave (MSB first) that loads or reads back words of the
// processor's single-port RAM. Frame: 8-bit command (0x01 write, 0x02 read),
// ADDR_WIDTH-bit start address, then one or more DATA_WIDTH-bit words with
// auto-incrementing address. SPI pins are oversampled in the clk domain.
module spi_ram_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  spi_ram_loader_if.master  ram,
  output logic              busy,
  output logic              done
);

  // The receive shifter and bit counter serve all three fields, so they are
  // sized for the longest of command, address and data.
  localparam int MAX_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int RX_W   = (MAX_AD > 8) ? MAX_AD : 8;
  localparam int CNT_W  = $clog2(RX_W) + 1;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Synchronizers, packed as {sclk, cs_n, mosi}.
  logic [2:0] pin_s1_reg;
  logic [2:0] pin_s2_reg;
  logic       sclk_prev_reg;
  logic       cs_n_prev_reg;

  logic sclk_s;
  logic cs_n_s;
  logic mosi_s;
  logic rise;
  logic fall;
  logic cs_fall;
  logic cs_rise;

  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [RX_W-1:0]       rx_reg;
  logic [RX_W-1:0]       rx_next;
  logic [DATA_WIDTH-1:0] tx_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  is_read_reg;
  logic                  word_seen_reg;
  logic                  wr_pend_reg;
  logic                  rd_pend_reg;
  logic                  inc_pend_reg;
  logic                  done_reg;

  logic last_cmd;
  logic last_addr;
  logic last_data;
  logic cmd_ok;
  logic word_done;

  logic mem_en_c;
  logic mem_we_c;
  logic miso_c;
  logic busy_c;
  logic done_c;

  // Two-flop synchronizers plus one history flop for edge detection. The
  // cs_n history clears to 0 so that a host still holding cs_n low across a
  // reset never produces a falling edge: the loader then waits in IDLE for a
  // fresh frame instead of joining one halfway.
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_s1_reg    <= 3'b000;
      pin_s2_reg    <= 3'b000;
      sclk_prev_reg <= 1'b0;
      cs_n_prev_reg <= 1'b0;
    end else begin
      pin_s1_reg    <= {sclk, cs_n, mosi};
      pin_s2_reg    <= pin_s1_reg;
      sclk_prev_reg <= pin_s2_reg[2];
      cs_n_prev_reg <= pin_s2_reg[1];
    end
  end

  assign sclk_s  = pin_s2_reg[2];
  assign cs_n_s  = pin_s2_reg[1];
  assign mosi_s  = pin_s2_reg[0];
  assign rise    = sclk_s & ~sclk_prev_reg;
  assign fall    = ~sclk_s & sclk_prev_reg;
  assign cs_fall = ~cs_n_s & cs_n_prev_reg;
  assign cs_rise = cs_n_s & ~cs_n_prev_reg;

  assign rx_next   = {rx_reg[RX_W-2:0], mosi_s};
  assign last_cmd  = (bit_cnt_reg == CNT_W'(7));
  assign last_addr = (bit_cnt_reg == CNT_W'(ADDR_WIDTH - 1));
  assign last_data = (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1));
  assign cmd_ok    = (rx_next[7:0] == CMD_WRITE) || (rx_next[7:0] == CMD_READ);
  assign word_done = (state_reg == DATA) && rise && last_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; deselect returns to IDLE from any state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall) state_next = CMD;
      CMD:     if (rise && last_cmd) state_next = cmd_ok ? ADDR : IGNORE;
      ADDR:    if (rise && last_addr) state_next = DATA;
      default: state_next = state_reg;
    endcase
    if (cs_rise) begin
      state_next = IDLE;
    end
  end

  // Frame datapath: bit counting, field capture, strobe scheduling, TX shift.
  // Strobes are one-cycle pending flags raised by the completing rise and
  // turned into mem_en on the following cycle. A completed write word keeps
  // its strobe even if deselect lands in the same cycle; pending reads are
  // dropped on deselect since nobody will clock the data out.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg   <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      addr_reg      <= '0;
      is_read_reg   <= 1'b0;
      word_seen_reg <= 1'b0;
      wr_pend_reg   <= 1'b0;
      rd_pend_reg   <= 1'b0;
      inc_pend_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      wr_pend_reg  <= 1'b0;
      rd_pend_reg  <= 1'b0;
      inc_pend_reg <= 1'b0;
      done_reg     <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            is_read_reg   <= 1'b0;
            word_seen_reg <= 1'b0;
          end
        end
        CMD: begin
          if (rise) begin
            rx_reg <= rx_next;
            if (last_cmd) begin
              bit_cnt_reg <= '0;
              is_read_reg <= (rx_next[7:0] == CMD_READ);
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
          end
        end
        ADDR: begin
          if (rise) begin
            rx_reg <= rx_next;
            if (last_addr) begin
              bit_cnt_reg <= '0;
              addr_reg    <= rx_next[ADDR_WIDTH-1:0];
              rd_pend_reg <= is_read_reg;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (rise) begin
            rx_reg <= rx_next;
            if (last_data) begin
              bit_cnt_reg   <= '0;
              word_seen_reg <= 1'b1;
              wr_pend_reg   <= ~is_read_reg;
              inc_pend_reg  <= is_read_reg;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
          end
          // The fall right after a word boundary must keep the freshly
          // loaded MSB on miso; only falls inside a word advance the shifter.
          if (fall && is_read_reg && (bit_cnt_reg != '0)) begin
            tx_reg <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: begin
        end
      endcase

      // Address advances after each write strobe, and before each follow-on read.
      if (wr_pend_reg || inc_pend_reg) begin
        addr_reg <= addr_reg + ADDR_WIDTH'(1);
      end
      if (inc_pend_reg) begin
        rd_pend_reg <= 1'b1;
      end
      if (rd_pend_reg) begin
        tx_reg <= ram.mem_rdata;
      end

      if (cs_rise && (state_reg != IDLE)) begin
        done_reg     <= (state_reg == DATA) && (word_seen_reg || word_done);
        tx_reg       <= '0;
        rd_pend_reg  <= 1'b0;
        inc_pend_reg <= 1'b0;
      end
    end
  end

  // Outputs: strobes from the pending flags; miso shows the RAM MSB during
  // the read strobe itself, then the TX shifter (zero outside read data).
  always_comb begin
    mem_en_c = wr_pend_reg | rd_pend_reg;
    mem_we_c = wr_pend_reg;
    miso_c   = rd_pend_reg ? ram.mem_rdata[DATA_WIDTH-1] : tx_reg[DATA_WIDTH-1];
    busy_c   = (state_reg != IDLE);
    done_c   = done_reg;
  end

  assign ram.mem_en    = mem_en_c;
  assign ram.mem_we    = mem_we_c;
  assign ram.mem_addr  = addr_reg;
  assign ram.mem_wdata = rx_reg[DATA_WIDTH-1:0];
  assign miso          = miso_c;
  assign busy          = busy_c;
  assign done          = done_c;

endmodule

// File: tb/tb_spi_ram_loader.sv
// Bench for spi_ram_loader: a host drives SPI frames, a RAM model answers
// the bus, and a reference model predicts the strobes, read stream and done.
module tb_spi_ram_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso;
  logic busy;
  logic done;

  spi_ram_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ram_if ();

  spi_ram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .sclk (sclk),
    .cs_n (cs_n),
    .mosi (mosi),
    .miso (miso),
    .ram  (ram_if),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } strobe_t;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  bit miso_zero_req = 1'b1;
  bit ram_init = 1'b0;
  bit prev_en = 1'b0;
  int frame_no = 0;

  strobe_t exp_q[$];
  strobe_t strobe_log[$];
  strobe_t cur_e;

  logic [31:0] ref_mem [0:255];
  logic [31:0] ram_mem [0:255];
  logic [31:0] frame_words [0:3];
  logic [31:0] miso_words [0:3];
  logic [31:0] exp_rd [0:3];

  // RAM seen by the DUT: combinational read, write on strobe.
  assign ram_if.mem_rdata = ram_mem[ram_if.mem_addr];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= ref_mem[i];
    end else if (ram_if.mem_en && ram_if.mem_we) begin
      ram_mem[ram_if.mem_addr] <= ram_if.mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  // Per-cycle compare of the RAM bus and idle miso against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ram_if.mem_we && !ram_if.mem_en) begin
        errors++;
        $display("FAIL we_without_en: got mem_we=1 mem_en=0, required mem_we=0");
      end
      checks++;
      if (ram_if.mem_en && prev_en) begin
        errors++;
        $display("FAIL en_width: got mem_en high 2 consecutive cycles, required 1");
      end
      if (ram_if.mem_en) begin
        strobe_log.push_back('{ram_if.mem_we, ram_if.mem_addr, ram_if.mem_wdata});
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got we=%0b addr=%h data=%h, required no strobe",
                   ram_if.mem_we, ram_if.mem_addr, ram_if.mem_wdata);
        end else begin
          cur_e = exp_q.pop_front();
          if (ram_if.mem_we !== cur_e.we || ram_if.mem_addr !== cur_e.addr ||
              (cur_e.we && ram_if.mem_wdata !== cur_e.data)) begin
            errors++;
            $display("FAIL strobe: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                     ram_if.mem_we, ram_if.mem_addr, ram_if.mem_wdata,
                     cur_e.we, cur_e.addr, cur_e.data);
          end
        end
      end
      if (miso_zero_req) begin
        checks++;
        if (miso !== 1'b0) begin
          errors++;
          $display("FAIL miso_idle: got %b required 0", miso);
        end
      end
      prev_en = ram_if.mem_en;
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: got simulation still running, required $finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // One SPI bit: mosi set while sclk low, miso sampled just before the rise.
  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    repeat (5) @(negedge clk);
    s = miso;
    sclk = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Full frame with model prediction; nbits counts bits after the address.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input int nbits);
    int nfull;
    int nstrobe;
    int exp_done;
    logic [7:0] a;
    logic s;
    nfull = nbits / 32;
    exp_done = 0;
    nstrobe = 0;
    exp_q.delete();
    strobe_log.delete();
    if (cmd == 8'h01) begin
      for (int i = 0; i < nfull; i++) begin
        a = addr + 8'(i);
        exp_q.push_back('{1'b1, a, frame_words[i]});
        ref_mem[a] = frame_words[i];
      end
      nstrobe = nfull;
      exp_done = (nfull >= 1) ? 1 : 0;
    end else if (cmd == 8'h02) begin
      for (int i = 0; i <= nfull; i++) begin
        a = addr + 8'(i);
        exp_q.push_back('{1'b0, a, 32'h0});
        if (i < nfull) exp_rd[i] = ref_mem[a];
      end
      nstrobe = nfull + 1;
      exp_done = (nfull >= 1) ? 1 : 0;
    end
    done_cnt = 0;
    miso_zero_req = (cmd != 8'h02);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_active", {63'd0, busy}, 64'd1);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], s);
    for (int i = 7; i >= 0; i--) spi_bit(addr[i], s);
    for (int j = 0; j < nbits; j++) begin
      spi_bit(frame_words[j / 32][31 - (j % 32)], s);
      miso_words[j / 32][31 - (j % 32)] = s;
    end
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_release", {63'd0, busy}, 64'd0);
    miso_zero_req = 1'b1;
    repeat (4) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("strobes_pending", 64'(exp_q.size()), 64'd0);
    if (cmd == 8'h02) begin
      for (int i = 0; i < nfull; i++) check("read_word", {32'd0, miso_words[i]}, {32'd0, exp_rd[i]});
    end
    $display("frame %0d: cmd=%h addr=%h data_bits=%0d strobes=%0d done=%0d",
             frame_no, cmd, addr, nbits, nstrobe, exp_done);
    frame_no++;
    exp_q.delete();
  endtask

  initial begin
    logic s;
    int kind;
    int nw;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] last_wr_addr;

    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'h0123_0007;
    ref_mem[1] = 32'h1234_0000;
    ram_init = 1'b1;
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    @(negedge clk);
    check("reset_mem_en", {63'd0, ram_if.mem_en}, 64'd0);
    check("reset_mem_we", {63'd0, ram_if.mem_we}, 64'd0);
    check("reset_mem_addr", {56'd0, ram_if.mem_addr}, 64'd0);
    check("reset_mem_wdata", {32'd0, ram_if.mem_wdata}, 64'd0);
    check("reset_miso", {63'd0, miso}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (6) @(negedge clk);

    // Read back preloaded words.
    run_frame(8'h02, 8'h00, 64);
    check("rb_word0", {32'd0, miso_words[0]}, 64'h0123_0007);
    check("rb_word1", {32'd0, miso_words[1]}, 64'h1234_0000);
    for (int i = 0; i < strobe_log.size(); i++) check("rb_we_low", {63'd0, strobe_log[i].we}, 64'd0);

    // Single write.
    frame_words[0] = 32'hDEADBEEF;
    run_frame(8'h01, 8'h05, 32);
    check("sw_count", 64'(strobe_log.size()), 64'd1);
    if (strobe_log.size() >= 1) begin
      check("sw_addr", {56'd0, strobe_log[0].addr}, 64'h05);
      check("sw_data", {32'd0, strobe_log[0].data}, 64'hDEADBEEF);
    end

    // Burst write across the top of memory.
    frame_words[0] = 32'h11111111;
    frame_words[1] = 32'h22222222;
    run_frame(8'h01, 8'hFF, 64);
    check("bw_count", 64'(strobe_log.size()), 64'd2);
    if (strobe_log.size() >= 2) begin
      check("bw_addr0", {56'd0, strobe_log[0].addr}, 64'hFF);
      check("bw_addr1", {56'd0, strobe_log[1].addr}, 64'h00);
    end

    // Abort mid-word, then a normal frame.
    frame_words[0] = 32'hCAFEF00D;
    run_frame(8'h01, 8'h10, 20);
    check("abort_count", 64'(strobe_log.size()), 64'd0);
    frame_words[0] = $urandom;
    run_frame(8'h01, 8'h11, 32);
    check("after_abort_count", 64'(strobe_log.size()), 64'd1);

    // Bad command.
    for (int i = 0; i < 4; i++) frame_words[i] = $urandom;
    run_frame(8'h7E, 8'hA5, 40);
    check("badcmd_count", 64'(strobe_log.size()), 64'd0);

    // Reset during the data phase of a write, cs_n held low.
    strobe_log.delete();
    exp_q.delete();
    done_cnt = 0;
    miso_zero_req = 1'b1;
    frame_words[0] = 32'hA5A5_5A5A;
    frame_words[1] = 32'h0F0F_F0F0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(((8'h01 >> i) & 8'h01) != 0, s);
    for (int i = 7; i >= 0; i--) spi_bit(((8'h33 >> i) & 8'h01) != 0, s);
    for (int j = 0; j < 10; j++) spi_bit(frame_words[0][31 - j], s);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mem_addr", {56'd0, ram_if.mem_addr}, 64'd0);
    check("rst_mem_wdata", {32'd0, ram_if.mem_wdata}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mem_en", {63'd0, ram_if.mem_en}, 64'd0);
    for (int j = 10; j < 64; j++) spi_bit(frame_words[j / 32][31 - (j % 32)], s);
    check("rst_idle_busy", {63'd0, busy}, 64'd0);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_done", 64'(done_cnt), 64'd0);
    check("rst_strobes", 64'(strobe_log.size()), 64'd0);
    $display("frame %0d: reset during write data, no strobe expected", frame_no);
    frame_no++;

    // Randomized frames.
    last_wr_addr = 8'h00;
    for (int f = 0; f < 16; f++) begin
      kind = $urandom_range(0, 3);
      addr = 8'($urandom_range(0, 255));
      nw = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) frame_words[i] = $urandom;
      case (kind)
        0: begin
          last_wr_addr = addr;
          run_frame(8'h01, addr, nw * 32);
        end
        1: begin
          if ($urandom_range(0, 1) == 1) addr = last_wr_addr;
          run_frame(8'h02, addr, nw * 32);
        end
        2: run_frame(8'h01, addr, $urandom_range(0, 2) * 32 + $urandom_range(1, 31));
        default: begin
          cmd = 8'($urandom_range(3, 255));
          run_frame(cmd, addr, nw * 32);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_loader.md
Name: spi_ram_loader

Overview:
- SPI slave (mode 0, MSB first) upstream of the processor's single-port RAM; drives the RAM port directly.
- Lets an external host load or read back words in program/data memory before and between processor runs.
- SPI pins are oversampled in the system clock domain; all RAM accesses are synchronous, single-cycle strobes.

Parameters:
- ADDR_WIDTH, 8, RAM address width; address field length on the wire; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width; data field length on the wire.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk; frequency <= clk/8.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out.
- mem_en  out  1  RAM enable strobe.
- mem_we  out  1  RAM write enable, valid with mem_en.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, combinational from mem_addr.
- busy  out  1  high while a frame is active (cs_n low after sync).
- done  out  1  one-cycle pulse at frame end if at least one full word was transferred.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters and shift registers cleared. Reset overrides every event in the same cycle.
- Input sync: sclk, cs_n and mosi each pass through 2 flops. Edge detect on synced sclk yields rise and fall pulses.
  - rise samples synced mosi.
  - fall updates miso.
- Frame format:
  - 8-bit command: 0x01 = write, 0x02 = read.
  - ADDR_WIDTH-bit start address.
  - Then N >= 1 words of DATA_WIDTH bits each.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE -> CMD on synced cs_n falling. busy = 1 and bit counter = 0.
  - CMD -> ADDR after the 8th rise if the command is 0x01 or 0x02; otherwise CMD -> IGNORE.
  - ADDR -> DATA after the ADDR_WIDTH-th rise; the address is loaded into mem_addr.
  - DATA: the bit counter wraps every DATA_WIDTH rises; the FSM stays in DATA until cs_n.
  - IGNORE: no RAM strobes; miso held at 0.
  - Any state -> IDLE on synced cs_n rising, in the same cycle; busy = 0.
- Write (cmd 0x01):
  - The cycle after the DATA_WIDTH-th rise of a word: mem_en = 1, mem_we = 1 for exactly 1 cycle, with mem_wdata = the assembled word and mem_addr = the current address.
  - The next cycle: mem_addr increments modulo DEPTH (DEPTH-1 wraps to 0).
- Read (cmd 0x02):
  - The cycle after the last address rise: mem_en = 1, mem_we = 0 for 1 cycle; mem_rdata is captured into the TX shift register. miso is driven with bit DATA_WIDTH-1 that same cycle.
  - Each subsequent fall shifts the next bit out.
  - The cycle after the DATA_WIDTH-th rise of a word: mem_addr increments modulo DEPTH, then a read strobe captures the next word and presents its MSB on miso before the next rise.
- miso is 0 outside the DATA phase of a read frame.
- Abort: cs_n rising mid-word discards the partial word; no write strobe for that word. Words completed earlier remain written.
- done pulses 1 cycle on the return to IDLE iff the word count is >= 1; an IGNORE frame never pulses done.
- mem_en is never high for more than 1 consecutive cycle. mem_we = 0 whenever mem_en = 0.

Test Plan:
- Single write: cmd 0x01, addr 0x05, data 0xDEADBEEF -> exactly one cycle with mem_en = 1, mem_we = 1, mem_addr = 0x05, mem_wdata = 0xDEADBEEF; done pulses once after cs_n rises.
- Burst write with wrap: cmd 0x01, addr 0xFF, words 0x11111111 and 0x22222222 -> writes to 0xFF, then 0x00; no other strobes.
- Read back: RAM model preloaded with 0x0123_0007 at 0x00 and 0x1234_0000 at 0x01; cmd 0x02, addr 0x00, 64 clocks -> miso stream 0x01230007 then 0x12340000; mem_we stays 0 throughout.
- Abort mid-word: cmd 0x01, addr 0x10, 20 data bits, then cs_n high -> no mem_en; done = 0; busy = 0 within 3 clk; the next valid frame works normally.
- Bad command: cmd 0x7E, 48 further bits -> no mem_en; miso = 0; no done pulse.
- Reset mid-frame: rst asserted during DATA of a write -> all outputs 0 the next cycle; no write strobe; FSM in IDLE even while cs_n is still low.
